prog_lut_ram: RTL and testbench

- Parametrised, writable lookup table. Successor to the fixed 16x4 combinational function ROM.
- Table auto-initialises to the identity map F=addr after reset or on request.
- Entries can be rewritten at run time.
- Lookups use a valid/ready pipelined read path with registered output and full backpressure.
- Sits between the switch/address front end and the display/output logic.

---
 rtl/prog_lut_ram.sv | 170 +++++++++++++++++
 tb/tb_prog_lut_ram.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_lut_ram.sv
// prog_lut_ram: writable 2**ADDR_W x DATA_W lookup table, identity-initialised, with a valid/ready read pipeline.
// Define PROG_LUT_PARITY_EN to add per-entry even parity, the i_wr_par_flip injection input and the o_out_perr output.
module prog_lut_ram #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int OUT_REG = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init_req,
  output logic              o_busy,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
`ifdef PROG_LUT_PARITY_EN
  input  logic              i_wr_par_flip,
  output logic              o_out_perr,
`endif
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [ADDR_W-1:0] i_in_addr,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic [DATA_W-1:0] o_out_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            r_state, w_nextState;
  logic [ADDR_W-1:0] r_cnt, w_nextCnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_s1Valid;
  logic [ADDR_W-1:0] r_s1Addr;
  logic [DATA_W-1:0] r_s1Data;

  logic              w_flush, w_wrFire, w_bypass, w_accept;
  logic              w_s1Load, w_s1Advance;
  logic [DATA_W-1:0] w_initData, w_rdData;

  assign o_busy     = (r_state == INIT);
  assign w_flush    = (r_state == RUN) && i_init_req;
  assign w_wrFire   = i_wr_en && (r_state == RUN) && !i_init_req;
  assign w_initData = DATA_W'(r_cnt);
  assign w_s1Load   = !r_s1Valid || w_s1Advance;
  assign o_in_ready = !o_busy && w_s1Load;
  assign w_accept   = i_in_valid && o_in_ready;
  // Same-cycle write to the looked-up address is forwarded so the lookup sees the new value.
  assign w_bypass   = w_wrFire && (i_wr_addr == i_in_addr);
  assign w_rdData   = w_bypass ? i_wr_data : r_mem[i_in_addr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      INIT: begin
        w_nextCnt = r_cnt + ADDR_W'(1);
        if (&r_cnt) w_nextState = RUN;
      end
      RUN: begin
        if (i_init_req) begin
          w_nextState = INIT;
          w_nextCnt   = '0;
        end
      end
      default: w_nextState = INIT;
    endcase
  end

  // The array has no reset; the INIT sweep is the only thing that defines its contents.
  always_ff @(posedge i_clk) begin
    if (r_state == INIT) r_mem[r_cnt] <= w_initData;
    else if (w_wrFire) r_mem[i_wr_addr] <= i_wr_data;
  end

`ifdef PROG_LUT_PARITY_EN
  logic r_par [DEPTH];
  logic w_rdPerr;
  logic r_s1Perr;

  assign w_rdPerr = w_bypass ? i_wr_par_flip : (r_par[i_in_addr] ^ (^r_mem[i_in_addr]));

  always_ff @(posedge i_clk) begin
    if (r_state == INIT) r_par[r_cnt] <= ^w_initData;
    else if (w_wrFire) r_par[i_wr_addr] <= (^i_wr_data) ^ i_wr_par_flip;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_s1Perr <= 1'b0;
    else if (w_accept) r_s1Perr <= w_rdPerr;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Addr  <= '0;
      r_s1Data  <= '0;
    end else begin
      if (w_flush) r_s1Valid <= 1'b0;
      else if (w_s1Load) r_s1Valid <= w_accept;
      if (w_accept) begin
        r_s1Addr <= i_in_addr;
        r_s1Data <= w_rdData;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_outReg
      logic              r_s2Valid;
      logic [ADDR_W-1:0] r_s2Addr;
      logic [DATA_W-1:0] r_s2Data;
      logic              w_s2Load;

      assign w_s2Load    = !r_s2Valid || i_out_ready;
      assign w_s1Advance = r_s1Valid && w_s2Load;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_s2Valid <= 1'b0;
          r_s2Addr  <= '0;
          r_s2Data  <= '0;
        end else begin
          if (w_flush) r_s2Valid <= 1'b0;
          else if (w_s2Load) r_s2Valid <= r_s1Valid;
          if (w_s1Advance) begin
            r_s2Addr <= r_s1Addr;
            r_s2Data <= r_s1Data;
          end
        end
      end

      assign o_out_valid = r_s2Valid;
      assign o_out_addr  = r_s2Addr;
      assign o_out_data  = r_s2Data;

`ifdef PROG_LUT_PARITY_EN
      logic r_s2Perr;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_s2Perr <= 1'b0;
        else if (w_s1Advance) r_s2Perr <= r_s1Perr;
      end
      assign o_out_perr = r_s2Perr;
`endif
    end else begin : g_noOutReg
      assign w_s1Advance = r_s1Valid && i_out_ready;
      assign o_out_valid = r_s1Valid;
      assign o_out_addr  = r_s1Addr;
      assign o_out_data  = r_s1Data;
`ifdef PROG_LUT_PARITY_EN
      assign o_out_perr  = r_s1Perr;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_prog_lut_ram.sv
// Testbench for prog_lut_ram (ADDR_W=4, DATA_W=4, OUT_REG=1): table-driven vectors with a result scoreboard
// plus hand-written stall, flush and reset sequences.
module tb_prog_lut_ram;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 4;
  localparam int OUT_REG = 1;
  localparam int LAT     = 1 + OUT_REG;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              init_req = 1'b0;
  logic              busy;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
`ifdef PROG_LUT_PARITY_EN
  logic              wr_par_flip = 1'b0;
  logic              out_perr;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              perr;
    int                cyc;
    int                lat;
  } exp_t;

  typedef struct {
    bit                wr;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    bit                flip;
    bit                look;
    logic [ADDR_W-1:0] la;
    logic [DATA_W-1:0] ed;
    bit                ep;
  } vec_t;

  exp_t sbQ[$];

  prog_lut_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_REG(OUT_REG)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_init_req   (init_req),
    .o_busy       (busy),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
`ifdef PROG_LUT_PARITY_EN
    .i_wr_par_flip(wr_par_flip),
    .o_out_perr   (out_perr),
`endif
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_addr    (in_addr),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_addr   (out_addr),
    .o_out_data   (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Results are compared as they are consumed, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_output", {28'h0, out_addr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("out_addr", 32'(out_addr), 32'(e.addr));
        checkOutput("out_data", 32'(out_data), 32'(e.data));
`ifdef PROG_LUT_PARITY_EN
        checkOutput("out_perr", 32'(out_perr), 32'(e.perr));
`endif
        if (e.lat >= 0) checkOutput("latency", 32'(cyc - e.cyc), 32'(e.lat));
      end
    end
  end

  task automatic applyStimulus(input bit wr, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                               input bit flip, input bit look, input logic [ADDR_W-1:0] la,
                               input logic [DATA_W-1:0] ed, input bit ep, input int lat, output bit acc);
    exp_t e;
    wr_en    = wr;
    wr_addr  = wa;
    wr_data  = wd;
    in_valid = look;
    in_addr  = la;
`ifdef PROG_LUT_PARITY_EN
    wr_par_flip = flip;
`else
    if (flip) wr_en = wr;
`endif
    @(negedge clk);
    acc = look && in_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      e.addr = la;
      e.data = ed;
      e.perr = ep;
      e.cyc  = cyc - 1;
      e.lat  = lat;
      sbQ.push_back(e);
    end
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    in_valid = 1'b0;
    init_req = 1'b0;
`ifdef PROG_LUT_PARITY_EN
    wr_par_flip = 1'b0;
`endif
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (sbQ.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    checkOutput("drain_empty", 32'(sbQ.size()), 32'd0);
  endtask

  task automatic countBusy(input bit injectAt4, output int n);
    n = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      init_req = 1'b0;
      wr_en    = 1'b0;
      if (!busy) break;
      n++;
      if (injectAt4 && n == 4) begin
        init_req = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 4'h2;
        wr_data  = 4'hF;
      end
    end
  endtask

  task automatic pulseInit();
    init_req = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    sbQ.delete();
  endtask

  vec_t vecs[13];
  bit   acc;
  int   n;
  int   idx;
  logic [DATA_W-1:0] bpExp[3];

  initial begin
    vecs[0]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h5, 4'h5, 1'b0};
    vecs[1]  = '{1'b1, 4'h3, 4'hA, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h3, 4'hA, 1'b0};
    vecs[3]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h4, 4'h4, 1'b0};
    vecs[4]  = '{1'b1, 4'h7, 4'h1, 1'b0, 1'b1, 4'h7, 4'h1, 1'b0};
    vecs[5]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0};
    vecs[6]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b0};
    vecs[7]  = '{1'b1, 4'h2, 4'h6, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h2, 4'h6, 1'b1};
    vecs[9]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 4'h1, 1'b0};
    vecs[10] = '{1'b1, 4'h9, 4'hC, 1'b0, 1'b1, 4'h8, 4'h8, 1'b0};
    vecs[11] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h9, 4'hC, 1'b0};
    vecs[12] = '{1'b1, 4'hE, 4'h5, 1'b0, 1'b1, 4'hE, 4'h5, 1'b0};

    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd1);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_out_addr", 32'(out_addr), 32'd0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    countBusy(1'b0, n);
    checkOutput("busy_cycles_after_reset", 32'(n), 32'd16);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].flip, vecs[i].look,
                    vecs[i].la, vecs[i].ed, vecs[i].ep, LAT, acc);
      if (vecs[i].look) checkOutput("vec_in_ready", 32'(acc), 32'd1);
    end
    idle();
    drain();

    // Backpressure: addresses 1,2,3 with the consumer stalled.
    bpExp[0] = 4'h1;
    bpExp[1] = 4'h6;
    bpExp[2] = 4'hA;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'(idx + 1), bpExp[idx], 1'b0, -1, acc);
      if (acc) idx++;
      if (c == 2) checkOutput("stall_hold_data_early", 32'(out_data), 32'h1);
    end
    checkOutput("stall_accepts", 32'(idx), 32'd2);
    @(negedge clk);
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_hold_data", 32'(out_data), 32'h1);
    checkOutput("stall_hold_addr", 32'(out_addr), 32'h1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && idx < 3; c++) begin
      applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'(idx + 1), bpExp[idx], 1'b0, -1, acc);
      if (acc) idx++;
    end
    checkOutput("stall_all_accepted", 32'(idx), 32'd3);
    idle();
    drain();

    // Re-initialisation with lookups in flight; a mid-sweep init_req and write are ignored.
    applyStimulus(1'b1, 4'h3, 4'hD, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, -1, acc);
    out_ready = 1'b0;
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h3, 4'hD, 1'b0, -1, acc);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h3, 4'hD, 1'b0, -1, acc);
    idle();
    pulseInit();
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_busy", 32'(busy), 32'd1);
    countBusy(1'b1, n);
    checkOutput("busy_cycles_after_init", 32'(n), 32'd16);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h3, 4'h3, 1'b0, LAT, acc);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h2, 4'h2, 1'b0, LAT, acc);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h7, 4'h7, 1'b0, LAT, acc);
    idle();
    drain();

    // Reset asserted part-way through a sweep.
    out_ready = 1'b0;
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'hB, 4'hB, 1'b0, -1, acc);
    idle();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("pre_reset_out_data", 32'(out_data), 32'hB);
    pulseInit();
    for (int k = 0; k < 8; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd1);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_out_data", 32'(out_data), 32'd0);
    checkOutput("midreset_out_addr", 32'(out_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    countBusy(1'b0, n);
    checkOutput("busy_cycles_after_midreset", 32'(n), 32'd16);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'hB, 4'hB, 1'b0, LAT, acc);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b0, LAT, acc);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
